// File: rtl/free_slot_selector_pkg.sv
// Shared slot-array sizing for the allocation front end.
// N is the superscalar dispatch width, RS_SZ the number of reservation-station slots.
package free_slot_selector_pkg;

  localparam int N     = 3;
  localparam int RS_SZ = 16;

endpackage : free_slot_selector_pkg

// File: rtl/free_slot_selector_popcount_tree.sv
// Balanced adder tree counting the set bits of a vector of any width.
// The input is zero-padded to the next power of two so every level pairs cleanly.
module free_slot_selector_popcount_tree
  import free_slot_selector_pkg::*;
#(
  parameter  int WIDTH  = RS_SZ,
  localparam int CNT_W  = $clog2(WIDTH + 1),
  localparam int LEVELS = $clog2(WIDTH),
  localparam int PAD_W  = 1 << LEVELS
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CNT_W-1:0] count
);

  logic [PAD_W-1:0] padded_s;

  assign padded_s = PAD_W'(bits);

  // Every partial sum is bounded by WIDTH, so CNT_W bits suffice at each level.
  for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
    localparam int NODES = PAD_W >> lv;
    logic [CNT_W-1:0] sum_s [NODES];
    for (genvar j = 0; j < NODES; j++) begin : g_node
      if (lv == 0) begin : g_leaf
        assign sum_s[j] = CNT_W'(padded_s[j]);
      end else begin : g_add
        assign sum_s[j] = g_lvl[lv-1].sum_s[2*j] + g_lvl[lv-1].sum_s[2*j+1];
      end
    end
  end

  assign count = g_lvl[LEVELS].sum_s[0];

endmodule : free_slot_selector_popcount_tree

// File: rtl/free_slot_selector.sv
// Picks up to REQS free slots lowest-first as one-hot grants and reports the
// free-slot count plus dispatch capacity clamped to REQS (also registered).
module free_slot_selector
  import free_slot_selector_pkg::*;
#(
  parameter  int WIDTH  = RS_SZ,
  parameter  int REQS   = N,
  localparam int CNT_W  = $clog2(WIDTH + 1),
  localparam int SPOT_W = $clog2(REQS + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            req,
  output logic [REQS-1:0][WIDTH-1:0]  gnt_bus,
  output logic [CNT_W-1:0]            count_ones,
  output logic [SPOT_W-1:0]           spots,
  output logic [SPOT_W-1:0]           spots_q
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [CNT_W-1:0]  count_ones_s;
  logic [SPOT_W-1:0] spots_s;
  logic [SPOT_W-1:0] spots_q_r;

  free_slot_selector_popcount_tree #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .bits  (req),
    .count (count_ones_s)
  );

  // Each stage sees the free bits left over by earlier stages and isolates the lowest one.
  for (genvar i = 0; i < REQS; i++) begin : g_stage
    logic [WIDTH-1:0] avail_s;
    logic [WIDTH-1:0] gnt_s;
    if (i == 0) begin : g_first
      assign avail_s = req;
    end else begin : g_next
      assign avail_s = g_stage[i-1].avail_s & ~g_stage[i-1].gnt_s;
    end
    assign gnt_s      = avail_s & ~(avail_s - ONE_W);
    assign gnt_bus[i] = gnt_s;
  end

  // Clamp capacity at REQS, comparing at full integer width.
  always_comb begin
    spots_s = {SPOT_W{1'b0}};
    if (int'(count_ones_s) > REQS) begin
      spots_s = SPOT_W'(REQS);
    end else begin
      spots_s = SPOT_W'(count_ones_s);
    end
  end

  // One-cycle delayed capacity for the dispatch stage; reset takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      spots_q_r <= {SPOT_W{1'b0}};
    end else begin
      spots_q_r <= spots_s;
    end
  end

  assign count_ones = count_ones_s;
  assign spots      = spots_s;
  assign spots_q    = spots_q_r;

endmodule : free_slot_selector

// File: tb/tb_free_slot_selector.sv
// Self-checking bench: directed literal vectors plus randomized req on WIDTH=16 and WIDTH=7
// instances, checked every cycle against a bit-scanning reference model.
module tb_free_slot_selector;
  import free_slot_selector_pkg::*;

  localparam int W16 = RS_SZ;
  localparam int W7  = 7;
  localparam int R   = N;

  logic              clock;
  logic              reset;
  logic [W16-1:0]    req16;
  logic [W7-1:0]     req7;
  logic [R-1:0][W16-1:0] gnt16;
  logic [R-1:0][W7-1:0]  gnt7;
  logic [4:0]        cnt16;
  logic [2:0]        cnt7;
  logic [1:0]        spots16, spots7, spq16, spq7;

  int tests;
  int fails;
  bit q_valid;
  int exp_q16, exp_q7;

  free_slot_selector #(.WIDTH(RS_SZ), .REQS(N)) dut16 (
    .clock(clock), .reset(reset), .req(req16), .gnt_bus(gnt16),
    .count_ones(cnt16), .spots(spots16), .spots_q(spq16)
  );

  free_slot_selector #(.WIDTH(W7), .REQS(N)) dut7 (
    .clock(clock), .reset(reset), .req(req7), .gnt_bus(gnt7),
    .count_ones(cnt7), .spots(spots7), .spots_q(spq7)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: count set bits by scanning.
  function automatic int m_pop(input logic [15:0] r, input int w);
    int c = 0;
    for (int j = 0; j < w; j++) if (r[j]) c++;
    return c;
  endfunction

  // Reference: one-hot of the (k+1)-th lowest set bit, or zero if there are fewer.
  function automatic logic [15:0] m_gnt(input logic [15:0] r, input int w, input int k);
    int seen = 0;
    for (int j = 0; j < w; j++) begin
      if (r[j]) begin
        if (seen == k) return 16'h0001 << j;
        seen++;
      end
    end
    return 16'h0000;
  endfunction

  function automatic int m_clamp(input int c);
    return (c > R) ? R : c;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the registered capacity.
  always @(posedge clock) begin
    if (reset) begin
      exp_q16 <= 0;
      exp_q7  <= 0;
      q_valid <= 1'b1;
    end else begin
      exp_q16 <= m_clamp(m_pop(req16, W16));
      exp_q7  <= m_clamp(m_pop({9'd0, req7}, W7));
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clock) begin
    logic [15:0] r7;
    logic [15:0] acc;
    r7 = {9'd0, req7};
    acc = 16'h0000;
    for (int i = 0; i < R; i++) begin
      chk($sformatf("gnt16[%0d] req=%h", i, req16), gnt16[i], m_gnt(req16, W16, i));
      chk($sformatf("gnt7[%0d] req=%h", i, req7), {9'd0, gnt7[i]}, m_gnt(r7, W7, i));
      // Structural properties: one-hot-or-zero, disjoint, subset of req.
      if ($countones(gnt16[i]) > 1 || (gnt16[i] & acc) != 16'h0000 || (gnt16[i] & ~req16) != 16'h0000) begin
        tests++;
        fails++;
        $display("FAIL gnt16_props[%0d]: got 0x%0h with req 0x%0h", i, gnt16[i], req16);
      end
      acc = acc | gnt16[i];
    end
    chk("count16", cnt16, m_pop(req16, W16));
    chk("count7", cnt7, m_pop(r7, W7));
    chk("spots16", spots16, m_clamp(m_pop(req16, W16)));
    chk("spots7", spots7, m_clamp(m_pop(r7, W7)));
    if (q_valid) begin
      chk("spots_q16", spq16, exp_q16);
      chk("spots_q7", spq7, exp_q7);
    end
  end

  task automatic drive(input logic [15:0] r, input logic rst);
    @(posedge clock);
    #1;
    req16 = r;
    req7  = r[6:0];
    reset = rst;
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    q_valid = 1'b0;
    reset   = 1'b1;
    req16   = 16'h0000;
    req7    = 7'h00;

    drive(16'h0000, 1'b1);
    chk("lit_zero_gnt", gnt16, 48'h0);
    chk("lit_zero_cnt", cnt16, 5'd0);
    chk("lit_zero_spots", spots16, 2'd0);

    drive(16'b1010_0000_0100_1000, 1'b0);
    chk("lit_a_gnt0", gnt16[0], 16'h0008);
    chk("lit_a_gnt1", gnt16[1], 16'h0040);
    chk("lit_a_gnt2", gnt16[2], 16'h2000);
    chk("lit_a_cnt", cnt16, 5'd4);
    chk("lit_a_spots", spots16, 2'd3);

    drive(16'h8001, 1'b0);
    chk("lit_b_gnt0", gnt16[0], 16'h0001);
    chk("lit_b_gnt1", gnt16[1], 16'h8000);
    chk("lit_b_gnt2", gnt16[2], 16'h0000);
    chk("lit_b_cnt", cnt16, 5'd2);
    chk("lit_b_spots", spots16, 2'd2);
    chk("lit_b_gnt7_0", gnt7[0], 7'h01);
    chk("lit_b_gnt7_1", gnt7[1], 7'h00);

    drive(16'hFFFF, 1'b0);
    chk("lit_ones_gnt", gnt16, {16'h0004, 16'h0002, 16'h0001});
    chk("lit_ones_cnt", cnt16, 5'd16);
    chk("lit_ones_spots", spots16, 2'd3);
    chk("lit_ones_cnt7", cnt7, 3'd7);

    // Reset held two edges with all slots free, then released.
    drive(16'hFFFF, 1'b1);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("lit_rst_q", spq16, 2'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("lit_rel_q", spq16, 2'd3);
    req16 = 16'h0001;
    req7  = 7'h01;
    @(posedge clock);
    #1;
    chk("lit_one_q", spq16, 2'd1);

    for (int n = 0; n < 10000; n++) begin
      logic [15:0] r;
      case ($urandom_range(0, 3))
        0: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        1: r = 16'($urandom) | 16'($urandom);
        2: r = 16'h0001 << $urandom_range(0, 15);
        default: r = 16'($urandom);
      endcase
      drive(r, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      req7 = 7'($urandom);
    end

    @(posedge clock);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_free_slot_selector
